// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin share of the register file write port.
// Define RF_WB_ARB_STATS_EN to build the conflict/R0-drop counters.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        a_valid,
  input  logic [3:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [3:0]  write_reg,
  output logic [31:0] write_data,
  output logic        rf_we,
  input  logic [3:0]  read_rega,
  input  logic [3:0]  read_regb,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [31:0] fwd_data,
  output logic [15:0] conflict_cnt,
  output logic [15:0] r0_drop_cnt
);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  gnt_e        r_last;
  gnt_e        w_last_nxt;
  logic [3:0]  r_write_reg;
  logic [31:0] r_write_data;
  logic        r_rf_we;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_xfer;
  logic [3:0]  w_sel_reg;
  logic [31:0] w_sel_data;

  // The port served most recently loses a tie.
  always_comb begin
    w_grant_a  = a_valid && (!b_valid || r_last == GNT_B);
    w_grant_b  = b_valid && (!a_valid || r_last == GNT_A);
    a_ready    = !hold && w_grant_a;
    b_ready    = !hold && w_grant_b;
    w_xfer     = a_ready || b_ready;
    w_sel_reg  = a_ready ? a_reg : b_reg;
    w_sel_data = a_ready ? a_data : b_data;
    w_last_nxt = r_last;
    unique case (1'b1)
      a_ready: w_last_nxt = GNT_A;
      b_ready: w_last_nxt = GNT_B;
      default: w_last_nxt = r_last;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= GNT_B;
      r_write_reg  <= 4'd0;
      r_write_data <= 32'd0;
      r_rf_we      <= 1'b0;
    end else begin
      r_last  <= w_last_nxt;
      r_rf_we <= w_xfer && (w_sel_reg != 4'd0);
      if (w_xfer) begin
        r_write_reg  <= w_sel_reg;
        r_write_data <= w_sel_data;
      end
    end
  end

  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign rf_we      = r_rf_we;
  assign fwd_data   = r_write_data;
  assign fwd_a      = r_rf_we && (r_write_reg == read_rega)
                      && (read_rega != 4'd0);
  assign fwd_b      = r_rf_we && (r_write_reg == read_regb)
                      && (read_regb != 4'd0);

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_r0_drop_cnt;
  logic        w_conflict;
  logic        w_r0_drop;

  assign w_conflict = a_valid && b_valid && !hold;
  assign w_r0_drop  = w_xfer && (w_sel_reg == 4'd0);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= 16'd0;
      r_r0_drop_cnt  <= 16'd0;
    end else begin
      if (w_conflict && r_conflict_cnt != 16'hFFFF)
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      if (w_r0_drop && r_r0_drop_cnt != 16'hFFFF)
        r_r0_drop_cnt <= r_r0_drop_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign r0_drop_cnt  = r_r0_drop_cnt;
`else
  assign conflict_cnt = 16'h0000;
  assign r0_drop_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed table-driven bench for rf_wb_arbiter.
// Counter expectations scale with RF_WB_ARB_STATS_EN.
module tb_rf_wb_arbiter;

`ifdef RF_WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        hold;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic        rf_we;
  logic [3:0]  read_rega;
  logic [3:0]  read_regb;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] fwd_data;
  logic [15:0] conflict_cnt;
  logic [15:0] r0_drop_cnt;

  int n_chk;
  int n_err;

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .a_valid      (a_valid),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .rf_we        (rf_we),
    .read_rega    (read_rega),
    .read_regb    (read_regb),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .fwd_data     (fwd_data),
    .conflict_cnt (conflict_cnt),
    .r0_drop_cnt  (r0_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          hold;
    bit          av;
    logic [3:0]  ar;
    logic [31:0] ad;
    bit          bv;
    logic [3:0]  br;
    logic [31:0] bd;
    logic [3:0]  rra;
    logic [3:0]  rrb;
    bit          ea;
    bit          eb;
    bit          ewe;
    logic [3:0]  ewr;
    logic [31:0] ewd;
    bit          efa;
    bit          efb;
    logic [15:0] ecc;
    logic [15:0] er0;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; hold = 0;
    a_valid = 0; a_reg = 0; a_data = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    read_rega = 0; read_regb = 0;
  endtask

  initial begin
    bit exp_last_b;
    bit got_b;
    n_chk = 0;
    n_err = 0;

    // rst hold av ar ad bv br bd rra rrb | a b we wr wd fa fb cc r0
    tv[0]  = '{0,0,1,3,32'hDEADBEEF,0,0,0,0,0,
               1,0,0,0,0,0,0,0,0};
    tv[1]  = '{0,0,0,0,0,0,0,0,3,0,
               0,0,1,3,32'hDEADBEEF,1,0,0,0};
    tv[2]  = '{0,0,0,0,0,1,0,32'h12345678,3,0,
               0,1,0,3,32'hDEADBEEF,0,0,0,0};
    tv[3]  = '{0,0,0,0,0,0,0,0,0,0,
               0,0,0,0,32'h12345678,0,0,0,1};
    tv[4]  = '{0,0,1,1,32'hA1,1,2,32'hB2,0,0,
               1,0,0,0,32'h12345678,0,0,0,1};
    tv[5]  = '{0,0,1,1,32'hA1,1,2,32'hB2,0,0,
               0,1,1,1,32'hA1,0,0,1,1};
    tv[6]  = '{0,0,1,1,32'hA1,1,2,32'hB2,0,0,
               1,0,1,2,32'hB2,0,0,2,1};
    tv[7]  = '{0,0,1,1,32'hA1,1,2,32'hB2,0,0,
               0,1,1,1,32'hA1,0,0,3,1};
    tv[8]  = '{0,0,1,5,32'h55555555,0,0,0,2,2,
               1,0,1,2,32'hB2,1,1,4,1};
    tv[9]  = '{0,0,0,0,0,0,0,0,5,0,
               0,0,1,5,32'h55555555,1,0,4,1};
    tv[10] = '{0,1,1,7,32'h77,0,0,0,5,0,
               0,0,0,5,32'h55555555,0,0,4,1};
    tv[11] = tv[10];
    tv[12] = tv[10];
    tv[13] = '{1,0,1,7,32'h77,1,8,32'h88,5,0,
               0,1,0,5,32'h55555555,0,0,4,1};
    tv[14] = '{0,0,1,7,32'h77,1,8,32'h88,0,0,
               1,0,0,0,0,0,0,0,0};
    tv[15] = '{0,0,0,0,0,0,0,0,7,7,
               0,0,1,7,32'h77,1,1,1,0};
    tv[16] = '{0,0,0,0,0,0,0,0,0,0,
               0,0,0,7,32'h77,0,0,1,0};

    idle();
    rst = 1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = tv[i].rst; hold = tv[i].hold;
      a_valid = tv[i].av; a_reg = tv[i].ar; a_data = tv[i].ad;
      b_valid = tv[i].bv; b_reg = tv[i].br; b_data = tv[i].bd;
      read_rega = tv[i].rra; read_regb = tv[i].rrb;
      #1;
      chk($sformatf("v%0d a_ready", i), 32'(a_ready), 32'(tv[i].ea));
      chk($sformatf("v%0d b_ready", i), 32'(b_ready), 32'(tv[i].eb));
      chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tv[i].ewe));
      chk($sformatf("v%0d write_reg", i), 32'(write_reg),
          32'(tv[i].ewr));
      chk($sformatf("v%0d write_data", i), write_data, tv[i].ewd);
      chk($sformatf("v%0d fwd_data", i), fwd_data, tv[i].ewd);
      chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tv[i].efa));
      chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tv[i].efb));
      chk($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt),
          STATS ? 32'(tv[i].ecc) : 32'd0);
      chk($sformatf("v%0d r0_drop_cnt", i), 32'(r0_drop_cnt),
          STATS ? 32'(tv[i].er0) : 32'd0);
    end

    // Sustained contention: grants must alternate every cycle.
    exp_last_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      a_valid = 1; a_reg = 9;  a_data = 32'h900 + 32'(i);
      b_valid = 1; b_reg = 10; b_data = 32'hA00 + 32'(i);
      #1;
      chk($sformatf("rr%0d a_ready", i), 32'(a_ready),
          32'(exp_last_b));
      chk($sformatf("rr%0d b_ready", i), 32'(b_ready),
          32'(!exp_last_b));
      exp_last_b = !exp_last_b;
    end
    @(negedge clk);
    #1;
    chk("rr last write_reg", 32'(write_reg),
        exp_last_b ? 32'd10 : 32'd9);

    // A held valid; a newly arriving B must be served within 2 cycles.
    @(negedge clk);
    idle();
    a_valid = 1; a_reg = 4; a_data = 32'h4;
    @(negedge clk);
    b_valid = 1; b_reg = 6; b_data = 32'h6;
    got_b = 1'b0;
    for (int i = 0; i < 2 && !got_b; i++) begin
      #1;
      if (b_ready) got_b = 1'b1;
      else @(negedge clk);
    end
    chk("starve b served", 32'(got_b), 32'd1);

`ifdef RF_WB_ARB_STATS_EN
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    a_valid = 1; a_reg = 1;
    b_valid = 1; b_reg = 2;
    repeat (65540) @(negedge clk);
    #1;
    chk("conflict_cnt saturate", 32'(conflict_cnt), 32'h0000FFFF);
`endif

    @(negedge clk);
    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
